// File: rtl/aether_cmd_sequencer.sv
// aether_cmd_sequencer
//
// Host-side command scheduler for aether_engine. Commands are queued in a
// small FIFO and driven onto cmd_o one per clock, back-to-back when the
// queue allows. A command queued with its wait flag set stalls the stream
// after it is issued until the engine interrupt shows a fresh rising edge.
// The block then optionally issues the status-read/interrupt-clear word
// before resuming. An optional watchdog moves the block to ERROR when a wait
// lasts too long. ERROR is left only through flush_i or reset.
//
// Ports
//   clk_i          engine clock, all logic on the rising edge
//   rst_ni         asynchronous active-low reset
//   push_i         enqueue request, taken when push_i && push_ready_o
//   push_cmd_i     24-bit command word {instr, param_1, param_2}
//   push_wait_i    wait for the interrupt after this command is issued
//   push_ready_o   FIFO not full
//   flush_i        synchronous flush: empty FIFO, clear error, go IDLE
//   interrupt_i    engine interrupt (level, held until cleared)
//   cmd_o          registered command word to the engine
//   busy_o         sequencer active or commands pending
//   waiting_o      stalled on an interrupt
//   error_o        wait timed out
//   fill_o         FIFO occupancy
//   issued_count_o commands issued from the FIFO (auto-clears excluded)
module aether_cmd_sequencer #(
    parameter int unsigned Depth         = 16,
    parameter logic [23:0] NopCmd        = 24'h000000,
    parameter logic [23:0] StatsClrCmd   = 24'h000000,
    parameter bit          AutoClear     = 1'b1,
    parameter int unsigned TimeoutCycles = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [23:0]                  push_cmd_i,
    input  logic                         push_wait_i,
    output logic                         push_ready_o,
    input  logic                         flush_i,
    input  logic                         interrupt_i,
    output logic [23:0]                  cmd_o,
    output logic                         busy_o,
    output logic                         waiting_o,
    output logic                         error_o,
    output logic [$clog2(Depth+1)-1:0]   fill_o,
    output logic [15:0]                  issued_count_o
);

    localparam int unsigned PW = $clog2(Depth);
    localparam int unsigned CW = $clog2(Depth + 1);
    localparam logic [31:0] TO_LAST =
        (TimeoutCycles == 0) ? 32'd0 : 32'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CLEAR,
        S_ERROR
    } state_t;

    state_t         state_q, state_d;
    logic [23:0]    cmd_d;
    logic [24:0]    mem [Depth];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [15:0]    issued_q;
    logic [31:0]    timer_q, timer_d;
    logic           irq_prev_q;
    logic           irq_seen_q, irq_seen_d;

    logic           full, empty;
    logic           push_accept;
    logic           pop;
    logic           irq_edge;
    logic [24:0]    head;

    assign full        = (count_q == CW'(Depth));
    assign empty       = (count_q == '0);
    // Flush wins over a same-cycle push; a full FIFO drops the push even if
    // a pop frees a slot on the same edge.
    assign push_accept = push_i && !full && !flush_i;
    assign irq_edge    = interrupt_i && !irq_prev_q;
    assign head        = mem[rd_ptr_q];

    // Storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push_accept) begin
            mem[wr_ptr_q] <= {push_wait_i, push_cmd_i};
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = NopCmd;
        pop        = 1'b0;
        timer_d    = timer_q;
        irq_seen_d = irq_seen_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_ISSUE: begin
                    if (!empty) begin
                        pop   = 1'b1;
                        cmd_d = head[23:0];
                        if (head[24]) begin
                            state_d    = S_WAIT;
                            irq_seen_d = 1'b0;
                            timer_d    = '0;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_WAIT: begin
                    // The first WAIT cycle is the one where the wait command
                    // itself sits on cmd_o, so an edge there already counts.
                    // Checking the edge before the timer lets it win a tie.
                    if (irq_seen_q || irq_edge) begin
                        irq_seen_d = 1'b1;
                        state_d    = AutoClear ? S_CLEAR : S_ISSUE;
                    end else if (TimeoutCycles != 0 && timer_q == TO_LAST) begin
                        state_d = S_ERROR;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end
                S_CLEAR: begin
                    cmd_d   = StatsClrCmd;
                    state_d = S_ISSUE;
                end
                S_ERROR: begin
                    state_d = S_ERROR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cmd_o      <= NopCmd;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            timer_q    <= '0;
            irq_prev_q <= 1'b0;
            irq_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_o      <= cmd_d;
            timer_q    <= timer_d;
            irq_prev_q <= interrupt_i;
            irq_seen_q <= irq_seen_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_accept) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    issued_q <= issued_q + 16'd1;
                end
                if (push_accept && !pop) begin
                    count_q <= count_q + 1'b1;
                end else if (pop && !push_accept) begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

    assign push_ready_o   = !full;
    assign busy_o         = (state_q != S_IDLE) || !empty;
    assign waiting_o      = (state_q == S_WAIT);
    assign error_o        = (state_q == S_ERROR);
    assign fill_o         = count_q;
    assign issued_count_o = issued_q;

endmodule

// File: tb/tb_aether_cmd_sequencer.sv
// Bench for aether_cmd_sequencer. Main instance uses a status-clear word of
// 24'h500000 with no timeout; a second instance has an 8-cycle timeout.
// Expected command words go into a queue as stimulus is issued; a monitor
// pops one entry every cycle the main instance drives a non-NOP word.
module tb_aether_cmd_sequencer;

    logic        clk;
    logic        rst_n;

    logic        push, push_wait, flush, irq;
    logic [23:0] push_cmd;
    logic        ready, busy, waiting, error;
    logic [23:0] cmd;
    logic [4:0]  fill;
    logic [15:0] issued;

    logic        t_push, t_push_wait, t_flush, t_irq;
    logic [23:0] t_push_cmd;
    logic        t_ready, t_busy, t_waiting, t_error;
    logic [23:0] t_cmd;
    logic [4:0]  t_fill;
    logic [15:0] t_issued;

    int n_tests = 0;
    int n_fail  = 0;
    logic [23:0] exp_q [$];

    aether_cmd_sequencer #(
        .Depth(16), .NopCmd(24'h000000), .StatsClrCmd(24'h500000),
        .AutoClear(1'b1), .TimeoutCycles(0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .push_i(push), .push_cmd_i(push_cmd),
        .push_wait_i(push_wait), .push_ready_o(ready), .flush_i(flush),
        .interrupt_i(irq), .cmd_o(cmd), .busy_o(busy), .waiting_o(waiting),
        .error_o(error), .fill_o(fill), .issued_count_o(issued)
    );

    aether_cmd_sequencer #(
        .Depth(16), .NopCmd(24'h000000), .StatsClrCmd(24'h500000),
        .AutoClear(1'b1), .TimeoutCycles(8)
    ) dut_to (
        .clk_i(clk), .rst_ni(rst_n), .push_i(t_push), .push_cmd_i(t_push_cmd),
        .push_wait_i(t_push_wait), .push_ready_o(t_ready), .flush_i(t_flush),
        .interrupt_i(t_irq), .cmd_o(t_cmd), .busy_o(t_busy),
        .waiting_o(t_waiting), .error_o(t_error), .fill_o(t_fill),
        .issued_count_o(t_issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [23:0] c, input logic w);
        push      = 1'b1;
        push_cmd  = c;
        push_wait = w;
        tick();
        push      = 1'b0;
        push_wait = 1'b0;
    endtask

    task automatic do_push_to(input logic [23:0] c, input logic w);
        t_push      = 1'b1;
        t_push_cmd  = c;
        t_push_wait = w;
        tick();
        t_push      = 1'b0;
        t_push_wait = 1'b0;
    endtask

    // Scoreboard monitor: every non-NOP word must be the next expected one.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && cmd !== 24'h000000) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_cmd actual=%0h required=none", cmd);
            end else begin
                chk("cmd_seq", {8'h0, cmd}, {8'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        push = 1'b0; push_cmd = '0; push_wait = 1'b0; flush = 1'b0; irq = 1'b0;
        t_push = 1'b0; t_push_cmd = '0; t_push_wait = 1'b0; t_flush = 1'b0; t_irq = 1'b0;
        tick(); tick();
        chk("rst_cmd", {8'h0, cmd}, 32'h0);
        chk("rst_ready", {31'h0, ready}, 32'h1);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_fill", {27'h0, fill}, 32'h0);
        chk("rst_issued", {16'h0, issued}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Three back-to-back commands; first appears one edge after its push.
        exp_q.push_back(24'h120040);
        exp_q.push_back(24'h130002);
        exp_q.push_back(24'h140004);
        do_push(24'h120040, 1'b0);
        chk("lat_nop", {8'h0, cmd}, 32'h0);
        do_push(24'h130002, 1'b0);
        chk("b2b_1", {8'h0, cmd}, 32'h120040);
        do_push(24'h140004, 1'b0);
        chk("b2b_2", {8'h0, cmd}, 32'h130002);
        tick();
        chk("b2b_3", {8'h0, cmd}, 32'h140004);
        tick();
        chk("b2b_nop", {8'h0, cmd}, 32'h0);
        chk("b2b_issued", {16'h0, issued}, 32'd3);

        // Wait command, interrupt 20 cycles later, auto-clear then resume.
        exp_q.push_back(24'h300000);
        exp_q.push_back(24'h500000);
        exp_q.push_back(24'h600000);
        do_push(24'h300000, 1'b1);
        do_push(24'h600000, 1'b0);
        repeat (20) tick();
        chk("wait_state", {31'h0, waiting}, 32'h1);
        chk("wait_nop", {8'h0, cmd}, 32'h0);
        chk("wait_fill", {27'h0, fill}, 32'd1);
        irq = 1'b1;
        for (int i = 0; i < 10 && cmd !== 24'h500000; i++) tick();
        chk("clr_seen", {8'h0, cmd}, 32'h500000);
        tick();
        chk("after_clr", {8'h0, cmd}, 32'h600000);
        irq = 1'b0;
        tick(); tick();
        chk("wait_issued", {16'h0, issued}, 32'd5);
        chk("wait_idle", {31'h0, busy}, 32'h0);

        // Interrupt level already high at wait entry does not satisfy it.
        irq = 1'b1;
        tick(); tick();
        exp_q.push_back(24'h700000);
        exp_q.push_back(24'h500000);
        exp_q.push_back(24'h800000);
        do_push(24'h700000, 1'b1);
        do_push(24'h800000, 1'b0);
        repeat (10) tick();
        chk("level_wait", {31'h0, waiting}, 32'h1);
        chk("level_nop", {8'h0, cmd}, 32'h0);
        irq = 1'b0;
        tick();
        irq = 1'b1;
        for (int i = 0; i < 10 && cmd !== 24'h500000; i++) tick();
        chk("level_clr", {8'h0, cmd}, 32'h500000);
        tick();
        chk("level_next", {8'h0, cmd}, 32'h800000);
        irq = 1'b0;
        tick();
        chk("level_issued", {16'h0, issued}, 32'd7);

        // Timeout instance: 8 WAIT cycles then ERROR; FIFO frozen; flush.
        do_push_to(24'h300000, 1'b1);
        repeat (8) tick();
        chk("to_still_wait", {31'h0, t_waiting}, 32'h1);
        chk("to_no_err_yet", {31'h0, t_error}, 32'h0);
        tick();
        chk("to_error", {31'h0, t_error}, 32'h1);
        chk("to_cmd_nop", {8'h0, t_cmd}, 32'h0);
        do_push_to(24'h100001, 1'b0);
        tick();
        chk("to_frozen_fill", {27'h0, t_fill}, 32'd1);
        chk("to_frozen_cmd", {8'h0, t_cmd}, 32'h0);
        t_flush = 1'b1;
        tick();
        t_flush = 1'b0;
        chk("to_flush_err", {31'h0, t_error}, 32'h0);
        chk("to_flush_fill", {27'h0, t_fill}, 32'd0);
        chk("to_flush_busy", {31'h0, t_busy}, 32'h0);
        chk("to_issued", {16'h0, t_issued}, 32'd1);

        // Fill the FIFO while stalled; 17th push dropped; flush beats push.
        exp_q.push_back(24'h900000);
        do_push(24'h900000, 1'b1);
        tick(); tick();
        for (int i = 0; i < 17; i++) begin
            do_push(24'hA00000 | 24'(i), 1'b0);
            if (i == 15) begin
                chk("full_fill", {27'h0, fill}, 32'd16);
                chk("full_ready", {31'h0, ready}, 32'h0);
            end
        end
        chk("drop_fill", {27'h0, fill}, 32'd16);
        push = 1'b1; push_cmd = 24'hB00000; flush = 1'b1;
        tick();
        push = 1'b0; flush = 1'b0;
        chk("flush_fill", {27'h0, fill}, 32'd0);
        chk("flush_wait", {31'h0, waiting}, 32'h0);
        chk("flush_ready", {31'h0, ready}, 32'h1);
        chk("flush_issued", {16'h0, issued}, 32'd8);

        // Asynchronous reset in the middle of a wait with 5 queued.
        exp_q.push_back(24'hB00001);
        do_push(24'hB00001, 1'b1);
        for (int i = 0; i < 5; i++) do_push(24'hC00000 | 24'(i), 1'b0);
        tick(); tick();
        chk("pre_rst_wait", {31'h0, waiting}, 32'h1);
        chk("pre_rst_fill", {27'h0, fill}, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cmd", {8'h0, cmd}, 32'h0);
        chk("arst_fill", {27'h0, fill}, 32'd0);
        chk("arst_wait", {31'h0, waiting}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_issued", {16'h0, issued}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.push_back(24'hD00000);
        do_push(24'hD00000, 1'b0);
        tick();
        chk("post_rst_cmd", {8'h0, cmd}, 32'hD00000);
        tick();
        chk("post_rst_issued", {16'h0, issued}, 32'd1);

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
